// File: rtl/alu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// alu_instr_sequencer
//
// Hardwired control unit for the single-bus datapath. It fetches an
// instruction (PC -> MAR, PC+1 -> Z -> PC, Mdata -> MDR -> IR), decodes the
// register-register ALU class plus nop/halt, and drives one cycle of
// datapath strobes per T-state. All strobes are Moore outputs decoded from
// the state register (T4..T7 also look at the already-latched ir).
//
// Ports
//   clock      : system clock, rising edge
//   clear      : asynchronous active-low reset
//   run        : start/continue, sampled only in IDLE and at instruction end
//   mem_ready  : memory read data valid on Mdata (watched in T2)
//   ir[31:0]   : current IR contents from the datapath
//   regIn      : one-hot register write strobes
//   regOut     : one-hot register bus-drive strobes
//   HiIn LoIn ZIn PCIn MDRIn MARIn IRIn YIn : register load strobes
//   HiOut LoOut ZHiOut ZLoOut PCOut MDROut  : bus-drive strobes
//   MDRread    : MDR input mux selects Mdata
//   IncPC      : ALU computes bus+1
//   ALUcode    : ALU operation select
//   halted     : high in HALT
//   illegal    : one-cycle pulse in T4 on an undefined opcode
//   bus_fault  : sticky memory-timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module alu_instr_sequencer #(
    parameter int MEM_TIMEOUT = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic [15:0] regIn,
    output logic [15:0] regOut,
    output logic        HiIn,
    output logic        LoIn,
    output logic        ZIn,
    output logic        PCIn,
    output logic        MDRIn,
    output logic        MARIn,
    output logic        IRIn,
    output logic        YIn,
    output logic        HiOut,
    output logic        LoOut,
    output logic        ZHiOut,
    output logic        ZLoOut,
    output logic        PCOut,
    output logic        MDROut,
    output logic        MDRread,
    output logic        IncPC,
    output logic [4:0]  ALUcode,
    output logic        halted,
    output logic        illegal,
    output logic        bus_fault
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_BIN, C_MULDIV, C_UNARY, C_NOP, C_HALT, C_ILLEGAL
    } op_class_t;

    // Wide enough to hold MEM_TIMEOUT-1 for any legal parameter value.
    localparam int CW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   wait_cnt;
    logic            bus_fault_q;
    logic            timeout;
    op_class_t       op_class;

    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;

    assign op = ir[31:27];
    assign ra = ir[26:23];
    assign rb = ir[22:19];
    assign rc = ir[18:15];

    // Immediate/address field is not used by this instruction class.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[14:0];

    function automatic op_class_t classify(input logic [4:0] code);
        case (code)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011: classify = C_BIN;
            5'b01111, 5'b10000:                               classify = C_MULDIV;
            5'b10001, 5'b10010:                               classify = C_UNARY;
            5'b11010:                                         classify = C_NOP;
            5'b11011:                                         classify = C_HALT;
            default:                                          classify = C_ILLEGAL;
        endcase
    endfunction

    function automatic logic [15:0] one_hot(input logic [3:0] idx);
        one_hot = 16'd1 << idx;
    endfunction

    assign op_class = classify(op);

    // The wait counter is zero on the first T2 cycle; the last permitted
    // cycle is MEM_TIMEOUT-1, so T2 lasts at most MEM_TIMEOUT cycles.
    assign timeout = (state == S_T2) && !mem_ready && (wait_cnt == WAIT_LAST);

    // ---------------------------------------------------------------------
    // State, wait counter and sticky fault flag
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            bus_fault_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_T2) begin
                wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (timeout) begin
                bus_fault_q <= 1'b1;
            end
        end
    end

    assign bus_fault = bus_fault_q;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_t instr_end;
        instr_end  = run ? S_T0 : S_IDLE;
        state_next = state;
        case (state)
            S_IDLE: if (run) state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1:   state_next = S_T2;
            S_T2: begin
                // mem_ready takes priority over a timeout on the same edge.
                if (mem_ready)    state_next = S_T3;
                else if (timeout) state_next = S_HALT;
            end
            S_T3:   state_next = S_T4;
            S_T4: begin
                case (op_class)
                    C_BIN, C_MULDIV, C_UNARY: state_next = S_T5;
                    C_HALT:                   state_next = S_HALT;
                    default:                  state_next = instr_end;
                endcase
            end
            S_T5:   state_next = (op_class == C_UNARY) ? instr_end : S_T6;
            S_T6:   state_next = (op_class == C_MULDIV) ? S_T7 : instr_end;
            S_T7:   state_next = instr_end;
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output decode: at most one bus driver per state
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        regIn   = '0;
        regOut  = '0;
        HiIn    = 1'b0;
        LoIn    = 1'b0;
        ZIn     = 1'b0;
        PCIn    = 1'b0;
        MDRIn   = 1'b0;
        MARIn   = 1'b0;
        IRIn    = 1'b0;
        YIn     = 1'b0;
        HiOut   = 1'b0;
        LoOut   = 1'b0;
        ZHiOut  = 1'b0;
        ZLoOut  = 1'b0;
        PCOut   = 1'b0;
        MDROut  = 1'b0;
        MDRread = 1'b0;
        IncPC   = 1'b0;
        ALUcode = '0;
        halted  = 1'b0;
        illegal = 1'b0;
        case (state)
            S_T0: begin
                PCOut = 1'b1;
                MARIn = 1'b1;
                IncPC = 1'b1;
                ZIn   = 1'b1;
            end
            S_T1: begin
                ZLoOut = 1'b1;
                PCIn   = 1'b1;
            end
            S_T2: begin
                MDRread = 1'b1;
                MDRIn   = 1'b1;
            end
            S_T3: begin
                MDROut = 1'b1;
                IRIn   = 1'b1;
            end
            S_T4: begin
                case (op_class)
                    C_BIN, C_MULDIV: begin
                        regOut = one_hot(rb);
                        YIn    = 1'b1;
                    end
                    C_UNARY: begin
                        regOut  = one_hot(rb);
                        ZIn     = 1'b1;
                        ALUcode = op;
                    end
                    C_ILLEGAL: illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    C_BIN, C_MULDIV: begin
                        regOut  = one_hot(rc);
                        ZIn     = 1'b1;
                        ALUcode = op;
                    end
                    C_UNARY: begin
                        ZLoOut = 1'b1;
                        regIn  = one_hot(ra);
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                ZLoOut = 1'b1;
                if (op_class == C_MULDIV) LoIn = 1'b1;
                else                      regIn = one_hot(ra);
            end
            S_T7: begin
                ZHiOut = 1'b1;
                HiIn   = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_instr_sequencer
//
// Self-checking bench. A behavioural model expands each instruction into
// the list of per-cycle strobe sets it must produce (fetch, memory wait,
// decode, execute), together with the ir and mem_ready values to drive on
// that cycle. The bench replays the list and compares every cycle.
// ---------------------------------------------------------------------------
module tb_alu_instr_sequencer;

    localparam int MEM_TIMEOUT = 8;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic [15:0] regIn, regOut;
    logic        HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, IRIn, YIn;
    logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut;
    logic        MDRread, IncPC;
    logic [4:0]  ALUcode;
    logic        halted, illegal, bus_fault;

    alu_instr_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .regIn(regIn), .regOut(regOut),
        .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn),
        .MARIn(MARIn), .IRIn(IRIn), .YIn(YIn),
        .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut),
        .PCOut(PCOut), .MDROut(MDROut),
        .MDRread(MDRread), .IncPC(IncPC), .ALUcode(ALUcode),
        .halted(halted), .illegal(illegal), .bus_fault(bus_fault)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] reg_in;
        logic [15:0] reg_out;
        logic hi_in, lo_in, z_in, pc_in, mdr_in, mar_in, ir_in, y_in;
        logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out;
        logic mdr_read, inc_pc;
        logic [4:0] alu_code;
        logic halted, illegal, bus_fault;
    } outs_t;

    typedef struct {
        outs_t       exp;
        bit          mr;
        logic [31:0] instr;
    } entry_t;

    entry_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic outs_t observe();
        outs_t o;
        o.reg_in  = regIn;   o.reg_out = regOut;
        o.hi_in   = HiIn;    o.lo_in   = LoIn;   o.z_in   = ZIn;   o.pc_in  = PCIn;
        o.mdr_in  = MDRIn;   o.mar_in  = MARIn;  o.ir_in  = IRIn;  o.y_in   = YIn;
        o.hi_out  = HiOut;   o.lo_out  = LoOut;  o.zhi_out = ZHiOut; o.zlo_out = ZLoOut;
        o.pc_out  = PCOut;   o.mdr_out = MDROut;
        o.mdr_read = MDRread; o.inc_pc = IncPC;  o.alu_code = ALUcode;
        o.halted  = halted;  o.illegal = illegal; o.bus_fault = bus_fault;
        return o;
    endfunction

    task automatic push(input outs_t o, input bit mr, input logic [31:0] instr);
        entry_t e;
        e.exp = o; e.mr = mr; e.instr = instr;
        q.push_back(e);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push('0, 1'($urandom_range(0, 1)), $urandom());
    endtask

    task automatic push_halt(input int n, input bit fault);
        outs_t o;
        for (int i = 0; i < n; i++) begin
            o = '0; o.halted = 1'b1; o.bus_fault = fault;
            push(o, 1'($urandom_range(0, 1)), $urandom());
        end
    endtask

    // Expected cycle list for one instruction. delay = cycles mem_ready stays
    // low in T2 (>= MEM_TIMEOUT means never). stops=1 when the machine ends
    // in HALT after this instruction.
    task automatic model_instr(input logic [31:0] instr, input int delay, output bit stops);
        outs_t o;
        int n;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
        stops = 1'b0;
        o = '0; o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
        push(o, 1'($urandom_range(0, 1)), instr);
        o = '0; o.zlo_out = 1; o.pc_in = 1;
        push(o, 1'($urandom_range(0, 1)), instr);
        n = (delay < MEM_TIMEOUT) ? delay + 1 : MEM_TIMEOUT;
        for (int i = 0; i < n; i++) begin
            o = '0; o.mdr_read = 1; o.mdr_in = 1;
            push(o, i == delay, instr);
        end
        if (delay >= MEM_TIMEOUT) begin
            stops = 1'b1;
            return;
        end
        o = '0; o.mdr_out = 1; o.ir_in = 1;
        push(o, 1'($urandom_range(0, 1)), instr);
        if ((op >= 3 && op <= 11) || op == 15 || op == 16) begin
            o = '0; o.reg_out = 16'd1 << rb; o.y_in = 1;
            push(o, 1'($urandom_range(0, 1)), instr);
            o = '0; o.reg_out = 16'd1 << rc; o.z_in = 1; o.alu_code = op;
            push(o, 1'($urandom_range(0, 1)), instr);
            o = '0; o.zlo_out = 1;
            if (op <= 11) o.reg_in = 16'd1 << ra;
            else          o.lo_in = 1;
            push(o, 1'($urandom_range(0, 1)), instr);
            if (op > 11) begin
                o = '0; o.zhi_out = 1; o.hi_in = 1;
                push(o, 1'($urandom_range(0, 1)), instr);
            end
        end else if (op == 17 || op == 18) begin
            o = '0; o.reg_out = 16'd1 << rb; o.z_in = 1; o.alu_code = op;
            push(o, 1'($urandom_range(0, 1)), instr);
            o = '0; o.zlo_out = 1; o.reg_in = 16'd1 << ra;
            push(o, 1'($urandom_range(0, 1)), instr);
        end else if (op == 26) begin
            push('0, 1'($urandom_range(0, 1)), instr);
        end else if (op == 27) begin
            push('0, 1'($urandom_range(0, 1)), instr);
            stops = 1'b1;
        end else begin
            o = '0; o.illegal = 1;
            push(o, 1'($urandom_range(0, 1)), instr);
        end
    endtask

    // Replays up to n queued cycles; called positioned inside a cycle, away
    // from the rising edge, and returns at the next falling edge.
    task automatic play(input string name, input int n);
        entry_t e;
        outs_t  got;
        for (int k = 0; k < n; k++) begin
            if (q.size() == 0) break;
            e = q.pop_front();
            ir = e.instr;
            mem_ready = e.mr;
            #1;
            got = observe();
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs got %h expected %h (ir=%h)",
                         name, k, got, e.exp, e.instr);
            end
            @(negedge clock);
        end
    endtask

    task automatic check_zero(input string name);
        outs_t got;
        got = observe();
        checks++;
        if (got !== outs_t'('0)) begin
            errors++;
            $display("FAIL %s: outputs got %h expected 0", name, got);
        end
    endtask

    task automatic do_reset();
        clear = 1'b0; run = 1'b0; mem_ready = 1'b0;
        #1;
        check_zero("reset_asserted");
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        #1;
        check_zero("reset_release");
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        push_idle(3);
        play("idle_run0", 3);
    endtask

    task automatic test_directed();
        bit s;
        do_reset();
        run = 1'b1;
        push_idle(1);
        model_instr(32'h421B8000, 0, s);   // rol R4,R3,R7
        model_instr(32'h79280000, 0, s);   // mul R2,R5
        model_instr(32'h88B00000, 0, s);   // neg R1,R6
        model_instr({5'b10010, 27'h5A5A5A5}, 0, s);   // not
        model_instr({5'b00100, 27'h1234567}, 0, s);   // sub
        play("directed", q.size());
    endtask

    task automatic test_mem_wait();
        bit s;
        do_reset();
        run = 1'b1;
        push_idle(1);
        model_instr(32'h18C40000, 3, s);                  // add, 3 wait cycles
        model_instr({5'b10000, 27'h3F0F0F0}, MEM_TIMEOUT - 1, s);  // ready on last allowed cycle
        model_instr({5'b01011, 27'h0000000}, 1, s);
        play("mem_wait", q.size());
    endtask

    task automatic test_timeout();
        bit s;
        do_reset();
        run = 1'b1;
        push_idle(1);
        model_instr(32'h18C40000, 100, s);
        push_halt(6, 1'b1);
        play("timeout", q.size());
    endtask

    task automatic test_illegal_halt();
        bit s;
        int n;
        do_reset();
        run = 1'b1;
        push_idle(1);
        model_instr({5'b11111, 27'h7654321}, 0, s);
        model_instr({5'b00000, 27'h0ABCDEF}, 1, s);
        model_instr({5'b11010, 27'h1111111}, 0, s);
        model_instr({5'b00101, 27'h2222222}, 0, s);
        model_instr({5'b11011, 27'h3333333}, 2, s);
        push_halt(8, 1'b0);
        n = q.size() - 8;
        play("illegal_halt", n);
        for (int i = 0; i < 8; i++) begin
            run = 1'($urandom_range(0, 1));
            play("halt_hold", 1);
        end
    endtask

    task automatic test_reset_mid();
        bit s;
        outs_t exp5, got;
        do_reset();
        run = 1'b1;
        push_idle(1);
        model_instr(32'h421B8000, 0, s);
        play("mid_prefix", 6);             // IDLE, T0..T4; now in T5
        q.delete();
        ir = 32'h421B8000;
        #1;
        exp5 = '0; exp5.reg_out = 16'h0080; exp5.z_in = 1; exp5.alu_code = 5'b01000;
        got = observe();
        checks++;
        if (got !== exp5) begin
            errors++;
            $display("FAIL rol_T5: outputs got %h expected %h", got, exp5);
        end
        clear = 1'b0;
        #1;
        check_zero("reset_mid_T5");
        do_reset();
        push_idle(4);
        play("after_mid_reset", 4);
    endtask

    task automatic test_run_gating();
        bit s;
        int n;
        do_reset();
        run = 1'b1;
        push_idle(1);
        model_instr({5'b11010, 27'h4444444}, 1, s);
        push_idle(4);
        play("gate_start", 2);
        run = 1'b0;                        // mid-instruction: ignored until end
        n = q.size();
        play("gate_to_idle", n);
        run = 1'b1;
        push_idle(1);
        model_instr({5'b00011, 27'h5555555}, 0, s);
        play("gate_restart", q.size());
    endtask

    task automatic test_back_to_back();
        bit s;
        logic [31:0] r;
        logic [4:0] op;
        logic [4:0] legal[15];
        legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                  5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd3};
        do_reset();
        run = 1'b1;
        push_idle(1);
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            if ($urandom_range(0, 3) != 0) op = legal[$urandom_range(0, 14)];
            else                           op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd28;
            model_instr({op, r[26:0]}, ($urandom_range(0, 2) == 0) ?
                        $urandom_range(0, MEM_TIMEOUT - 1) : 0, s);
        end
        play("random", q.size());
    endtask

    initial begin
        clear = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = '0;
        test_reset();
        test_directed();
        test_mem_wait();
        test_timeout();
        test_illegal_halt();
        test_reset_mid();
        test_run_gating();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
